hashout_reader: RTL and testbench
=================================

HASHOUT_READER -- requirements
Module: hashout_reader

Interface
REQ-001 SHALL have port: clk  input  1  global clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: hashout_empty  input  1  empty flag of the hashout FIFO.
REQ-004 SHALL have port: hashout_dout  input  32  hashout FIFO read data, valid exactly 1 cycle after hashout_re.
REQ-005 SHALL have port: hashout_re  output  1  hashout FIFO read enable.
REQ-006 SHALL have port: digest  output  256  assembled heavyhash digest.
REQ-007 SHALL have port: digest_valid  output  1  digest presented.
REQ-008 SHALL have port: digest_ready  input  1  downstream accepts digest.
REQ-009 SHALL have port: digest_cnt  output  32  number of digests accepted downstream.
REQ-010 SHALL have port (TARGET_CMP_EN only): target  input  256  difficulty target, sampled when the last word is captured.
REQ-011 SHALL have port (TARGET_CMP_EN only): hit  output  1  pulse, 1 cycle, when a digest <= target is captured.

Function
REQ-012 SHALL use states IDLE, READ, WAIT_LAST, OUT.
REQ-013 IDLE: if !hashout_empty, assert hashout_re, clear word_cnt, go READ; else stay.
REQ-014 READ: hashout_re = !hashout_empty; data returned 1 cycle after each accepted re SHALL be written to digest[32*w+31:32*w], w = word index 0..7 in pop order.
REQ-015 SHALL never assert hashout_re while hashout_empty = 1; an empty FIFO stalls READ with no word lost or duplicated.
REQ-016 Once 8 reads have been issued, SHALL deassert hashout_re and go WAIT_LAST; the 8th word is captured there, then go OUT.
REQ-017 OUT: digest_valid = 1, digest stable; on digest_valid & digest_ready, increment digest_cnt and go IDLE. The next pop occurs no earlier than the following cycle.
REQ-018 digest and digest_valid SHALL hold unchanged while digest_valid = 1 and digest_ready = 0.
REQ-019 digest_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-020 digest_valid, hashout_re and hit SHALL be driven from registers or state only, with no combinational path from digest_ready.
REQ-021 Throughput with a non-empty FIFO and ready held high: one digest per 11 cycles.

Reset
REQ-022 On rst_n = 0, SHALL immediately set state IDLE, hashout_re = 0, digest_valid = 0, hit = 0, digest = 0, digest_cnt = 0, word_cnt = 0.
REQ-023 Reset asserted mid-READ SHALL discard the partial digest; words already popped are lost.

Configuration
REQ-024 Macro TARGET_CMP_EN: when defined, target and hit ports exist.
REQ-025 With TARGET_CMP_EN, the unsigned 256-bit compare (digest <= target) SHALL be registered, and hit pulses in the cycle OUT is entered. All digests are still forwarded.
REQ-026 Without TARGET_CMP_EN, no compare logic and no target or hit ports SHALL exist.

Structure
REQ-027 Package heavyhash_pkg SHALL hold WORD_W = 32, WORDS_PER_DIGEST = 8, DIGEST_W = 256 and the reader state enum typedef.
REQ-028 The compare SHALL be sub-module hashout_cmp, instantiated only under TARGET_CMP_EN.

Verification
REQ-029 Preload FIFO with words 32'h0..32'h7, ready = 1 -> digest = {32'h7,...,32'h0}, valid 1 cycle, digest_cnt = 1.
REQ-030 Hold FIFO empty after word 3 for 5 cycles -> hashout_re = 0 while empty, final digest still words 0..7 in order.
REQ-031 ready = 0 for 10 cycles in OUT -> digest held, no pops, digest_cnt increments once.
REQ-032 Assert rst_n = 0 after 4 pops -> all outputs 0; 8 new words -> clean digest from those words.
REQ-033 TARGET_CMP_EN, target = 256'h1 with digest 256'h1 -> hit = 1; with digest 256'h2 -> hit = 0.
REQ-034 Force digest_cnt = 32'hFFFF_FFFF, complete a transfer -> digest_cnt = 0.

Source files
------------

// File: rtl/heavyhash_pkg.sv
// Shared widths and reader state encoding for the heavyhash output path.
//   WORD_W           : hashout FIFO word width
//   WORDS_PER_DIGEST : FIFO words assembled into one digest
//   DIGEST_W         : assembled digest width
//   reader_state_e   : hashout_reader FSM states
package heavyhash_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned WORDS_PER_DIGEST = 8;
  localparam int unsigned DIGEST_W         = 256;
  localparam int unsigned WCNT_W           = $clog2(WORDS_PER_DIGEST);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WAIT_LAST = 2'd2,
    OUT       = 2'd3
  } reader_state_e;

endpackage

// File: rtl/hashout_cmp.sv
// Registered difficulty check: hit is set for one cycle when the digest
// completed this cycle is <= target (unsigned).
//   clk, rst_n : clock, async active-low reset
//   en         : last word of a digest is being captured this cycle
//   value      : digest as it will be once the last word lands
//   target     : difficulty target
//   hit        : registered compare result, qualified by en
module hashout_cmp
  import heavyhash_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIGEST_W-1:0] value,
  input  logic [DIGEST_W-1:0] target,
  output logic                hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
    end else begin
      hit <= en && (value <= target);
    end
  end

endmodule

// File: rtl/hashout_reader.sv
// Pops eight 32-bit words from the hashout FIFO, assembles them into a
// 256-bit digest (first word popped in the low bits) and hands it downstream
// with a valid/ready handshake, counting accepted digests.
// Optional feature macro: TARGET_CMP_EN adds target/hit and the compare.
//   clk, rst_n      : clock, async active-low reset
//   hashout_empty   : FIFO empty flag
//   hashout_dout    : FIFO data, valid one cycle after hashout_re
//   hashout_re      : FIFO read enable
//   digest          : assembled digest
//   digest_valid    : digest presented
//   digest_ready    : downstream accepts digest
//   digest_cnt      : accepted digest count (wraps)
//   target, hit     : (TARGET_CMP_EN) difficulty target / 1-cycle hit pulse
module hashout_reader
  import heavyhash_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hashout_empty,
  input  logic [WORD_W-1:0]   hashout_dout,
  output logic                hashout_re,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [31:0]         digest_cnt
`ifdef TARGET_CMP_EN
  ,
  input  logic [DIGEST_W-1:0] target,
  output logic                hit
`endif
);

  reader_state_e     state;
  logic              re_en;      // read window open; still gated by empty
  logic              rd_pend;    // a word arrives on hashout_dout this cycle
  logic [WCNT_W-1:0] issue_cnt;  // reads issued for the current digest
  logic [WCNT_W-1:0] word_cnt;   // words captured for the current digest

  // The enable is a register; masking with empty keeps a drained FIFO from
  // ever seeing a read, so a stall neither loses nor duplicates a word.
  assign hashout_re = re_en & ~hashout_empty;

  // Reader FSM, word capture and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      re_en        <= 1'b0;
      rd_pend      <= 1'b0;
      issue_cnt    <= '0;
      word_cnt     <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      digest_cnt   <= '0;
    end else begin
      rd_pend <= hashout_re;
      if (rd_pend) begin
        digest[32'(word_cnt) * WORD_W +: WORD_W] <= hashout_dout;
        word_cnt <= word_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!hashout_empty) begin
            re_en     <= 1'b1;
            issue_cnt <= '0;
            word_cnt  <= '0;
            state     <= READ;
          end
        end
        READ: begin
          if (hashout_re) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == WCNT_W'(WORDS_PER_DIGEST - 1)) begin
              re_en <= 1'b0;
              state <= WAIT_LAST;
            end
          end
        end
        WAIT_LAST: begin
          // rd_pend is always set here: the final read was issued last cycle
          digest_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            digest_cnt   <= digest_cnt + 32'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TARGET_CMP_EN
  // Digest as it stands once the final word lands at the end of WAIT_LAST
  logic [DIGEST_W-1:0] digest_last;
  assign digest_last = {hashout_dout, digest[DIGEST_W-WORD_W-1:0]};

  hashout_cmp u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == WAIT_LAST),
    .value  (digest_last),
    .target (target),
    .hit    (hit)
  );
`endif

endmodule

// File: tb/tb_hashout_reader.sv
// Scoreboard bench for hashout_reader: a behavioural FIFO feeds words,
// expected digests are queued at stimulus time and checked by a monitor
// when digest_valid rises. Build with TARGET_CMP_EN to cover target/hit.
`timescale 1ns/1ps
module tb_hashout_reader;
  import heavyhash_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         hashout_empty;
  logic [31:0]  hashout_dout = '0;
  logic         hashout_re;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [31:0]  digest_cnt;
`ifdef TARGET_CMP_EN
  logic [255:0] target = '1;
  logic         hit;
`endif

  always #5 clk = ~clk;

  hashout_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hashout_empty (hashout_empty),
    .hashout_dout  (hashout_dout),
    .hashout_re    (hashout_re),
    .digest        (digest),
    .digest_valid  (digest_valid),
    .digest_ready  (digest_ready),
    .digest_cnt    (digest_cnt)
`ifdef TARGET_CMP_EN
    ,
    .target        (target),
    .hit           (hit)
`endif
  );

  // Behavioural FIFO: data appears one cycle after the read enable
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign hashout_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (hashout_re) begin
      hashout_dout <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rise_last = 0;
  int          rise_prev = 0;
  logic [31:0] exp_cnt = '0;

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = base + 32'(i);
    return d;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_exp(input logic [255:0] d);
    sb.push_back('{d: d, cnt: exp_cnt});
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic push_digest(input logic [31:0] base);
    for (int i = 0; i < 8; i++) push_word(base + 32'(i));
    push_exp(mk(base));
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (!digest_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!digest_valid) begin
      fails++;
      $display("FAIL %s timeout waiting for digest_valid", name);
    end
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    while ((sb.size() != 0 || digest_valid || !hashout_empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tests++;
    if (sb.size() != 0 || digest_valid) begin
      fails++;
      $display("FAIL %s timeout draining, %0d digests outstanding", name, sb.size());
    end
  endtask

  // Monitor: compare each presented digest against the scoreboard head
  task automatic monitor();
    logic pv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && hashout_re && hashout_empty) begin
        tests++;
        fails++;
        $display("FAIL re_while_empty at cycle %0d", cyc);
      end
      if (digest_valid && !pv) begin
        rise_prev = rise_last;
        rise_last = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_digest got=%h", digest);
        end else begin
          e = sb.pop_front();
          chk("digest", digest, e.d);
          chk("cnt_at_out", 256'(digest_cnt), 256'(e.cnt));
`ifdef TARGET_CMP_EN
          chk("hit", 256'(hit), 256'(e.d <= target));
`endif
        end
      end
      pv = digest_valid;
    end
  endtask

  initial begin
    logic [255:0] held;
    int           rd_snap;
    int           n;

    fork
      monitor();
    join_none

    // Reset values
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_digest", digest, '0);
    chk("rst_valid", 256'(digest_valid), 256'(0));
    chk("rst_re", 256'(hashout_re), 256'(0));
    chk("rst_cnt", 256'(digest_cnt), 256'(0));
`ifdef TARGET_CMP_EN
    chk("rst_hit", 256'(hit), 256'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic digest from words 0..7, valid for exactly one cycle
    digest_ready = 1'b1;
    push_digest(32'h0);
    wait_valid(40, "basic");
    @(negedge clk);
    chk("valid_one_cycle", 256'(digest_valid), 256'(0));
    chk("cnt_after_basic", 256'(digest_cnt), 256'(1));

    // Back-to-back digests: one every 11 cycles
    push_digest(32'h100);
    push_digest(32'h200);
    wait_drain(100, "throughput");
    chk("throughput_period", 256'(rise_last - rise_prev), 256'(11));

    // FIFO runs dry after word 3 for 5 cycles
    for (int i = 0; i < 4; i++) push_word(32'h300 + 32'(i));
    push_exp(mk(32'h300));
    n = 0;
    while (rd_ptr != wr_ptr && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_re", 256'(hashout_re), 256'(0));
    end
    for (int i = 4; i < 8; i++) push_word(32'h300 + 32'(i));
    wait_drain(60, "stall");

    // Backpressure: ready low for 10 cycles while a second digest waits
    digest_ready = 1'b0;
    push_digest(32'h400);
    push_digest(32'h500);
    wait_valid(40, "bp");
    held    = digest;
    rd_snap = rd_ptr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_digest_held", digest, held);
      chk("bp_valid_held", 256'(digest_valid), 256'(1));
      chk("bp_no_re", 256'(hashout_re), 256'(0));
    end
    chk("bp_no_pops", 256'(rd_ptr), 256'(rd_snap));
    chk("bp_cnt_before", 256'(digest_cnt), 256'(4));
    digest_ready = 1'b1;
    @(negedge clk);
    chk("bp_cnt_once", 256'(digest_cnt), 256'(5));
    wait_drain(60, "bp_drain");
    chk("bp_cnt_final", 256'(digest_cnt), 256'(6));

    // Reset after 4 pops discards the partial digest
    rd_snap = rd_ptr;
    for (int i = 0; i < 8; i++) push_word(32'h600 + 32'(i));
    n = 0;
    while (rd_ptr - rd_snap < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pops_reached", 256'(rd_ptr - rd_snap), 256'(4));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digest", digest, '0);
    chk("mid_rst_valid", 256'(digest_valid), 256'(0));
    chk("mid_rst_re", 256'(hashout_re), 256'(0));
    chk("mid_rst_cnt", 256'(digest_cnt), 256'(0));
`ifdef TARGET_CMP_EN
    chk("mid_rst_hit", 256'(hit), 256'(0));
`endif
    @(negedge clk);
    wr_ptr  = rd_ptr;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_digest(32'h700);
    wait_drain(60, "post_reset");
    chk("post_reset_cnt", 256'(digest_cnt), 256'(1));

    // Counter wrap
    force dut.digest_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.digest_cnt;
    @(negedge clk);
    exp_cnt = 32'hFFFF_FFFF;
    push_digest(32'h800);
    wait_drain(60, "wrap");
    chk("cnt_wrap", 256'(digest_cnt), 256'(0));

`ifdef TARGET_CMP_EN
    // Target compare: equal hits, greater misses
    target = 256'h1;
    push_word(32'h1);
    for (int i = 1; i < 8; i++) push_word(32'h0);
    push_exp(256'h1);
    push_word(32'h2);
    for (int i = 1; i < 8; i++) push_word(32'h0);
    push_exp(256'h2);
    wait_drain(100, "cmp");
    @(negedge clk);
    chk("hit_pulse_end", 256'(hit), 256'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
